// File: rtl/reg_file_8x16.sv
// Eight-entry register file with two async read ports and a pending-load scoreboard.
// Optional REGFILE_BYPASS_EN macro adds write-through forwarding on both read ports.
module reg_file_8x16 #(
  parameter int              WIDTH     = 16,
  parameter int              DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = 16'h0000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [2:0]       i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [2:0]       i_raddrA,
  input  logic [2:0]       i_raddrB,
  output logic [WIDTH-1:0] o_rdataA,
  output logic [WIDTH-1:0] o_rdataB,
  input  logic             i_setPend,
  input  logic [2:0]       i_pendAddr,
  output logic             o_readyA,
  output logic             o_readyB,
  output logic [DEPTH-1:0] o_pendVec
);

  localparam int AW = 3;

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_pend;

  logic             w_wrValid;
  logic [DEPTH-1:0] w_setMask;
  logic [DEPTH-1:0] w_clrMask;
  logic [DEPTH-1:0] w_pendNext;
  logic [WIDTH-1:0] w_storedA;
  logic [WIDTH-1:0] w_storedB;
  logic             w_hitA;
  logic             w_hitB;

  assign w_wrValid = i_we && (i_waddr != '0);

  // Set is applied after clear so a retiring load and a fresh load to the same register keep it pending.
  assign w_setMask  = (i_setPend && (i_pendAddr != '0)) ? (DEPTH'(1) << i_pendAddr) : '0;
  assign w_clrMask  = w_wrValid ? (DEPTH'(1) << i_waddr) : '0;
  assign w_pendNext = ((r_pend & ~w_clrMask) | w_setMask) & ~DEPTH'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_regs[0] <= '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_regs[i] <= RESET_VAL;
      end
      r_pend <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (w_wrValid && (i_waddr == AW'(i))) begin
          r_regs[i] <= i_wdata;
        end
      end
      r_pend <= w_pendNext;
    end
  end

  assign w_storedA = (i_raddrA == '0) ? '0 : r_regs[i_raddrA];
  assign w_storedB = (i_raddrB == '0) ? '0 : r_regs[i_raddrB];

`ifdef REGFILE_BYPASS_EN
  assign w_hitA = w_wrValid && (i_waddr == i_raddrA);
  assign w_hitB = w_wrValid && (i_waddr == i_raddrB);
`else
  assign w_hitA = 1'b0;
  assign w_hitB = 1'b0;
`endif

  assign o_rdataA  = w_hitA ? i_wdata : w_storedA;
  assign o_rdataB  = w_hitB ? i_wdata : w_storedB;
  assign o_readyA  = w_hitA | ~r_pend[i_raddrA];
  assign o_readyB  = w_hitB | ~r_pend[i_raddrB];
  assign o_pendVec = r_pend;

endmodule

// File: tb/tb_reg_file_8x16.sv
// Directed self-checking bench for reg_file_8x16; expectations follow REGFILE_BYPASS_EN when defined.
module tb_reg_file_8x16;

  logic        clk;
  logic        rstN;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddrA;
  logic [2:0]  raddrB;
  logic [15:0] rdataA;
  logic [15:0] rdataB;
  logic        setPend;
  logic [2:0]  pendAddr;
  logic        readyA;
  logic        readyB;
  logic [7:0]  pendVec;

  int compareCount;
  int failCount;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_file_8x16 dut (
    .i_clk     (clk),
    .i_rst_n   (rstN),
    .i_we      (we),
    .i_waddr   (waddr),
    .i_wdata   (wdata),
    .i_raddrA  (raddrA),
    .i_raddrB  (raddrB),
    .o_rdataA  (rdataA),
    .o_rdataB  (rdataB),
    .i_setPend (setPend),
    .i_pendAddr(pendAddr),
    .o_readyA  (readyA),
    .o_readyB  (readyB),
    .o_pendVec (pendVec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the write and scoreboard inputs for the next clock edge
  task automatic applyStimulus(input logic weIn, input logic [2:0] waddrIn,
                               input logic [15:0] wdataIn, input logic setIn,
                               input logic [2:0] pendIn);
    we       = weIn;
    waddr    = waddrIn;
    wdata    = wdataIn;
    setPend  = setIn;
    pendAddr = pendIn;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hard time limit so the run can never hang
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compareCount = 0;
    failCount    = 0;
    rstN   = 1'b0;
    raddrA = 3'd0;
    raddrB = 3'd0;
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);

    #12;
    rstN = 1'b1;
    for (int a = 0; a < 8; a++) begin
      raddrA = 3'(a);
      raddrB = 3'(7 - a);
      #1;
      checkOutput("reset_rdataA", rdataA, 16'h0000);
      checkOutput("reset_rdataB", rdataB, 16'h0000);
      checkOutput("reset_readyA", {15'd0, readyA}, 16'h0001);
      checkOutput("reset_readyB", {15'd0, readyB}, 16'h0001);
    end
    checkOutput("reset_pendVec", {8'd0, pendVec}, 16'h0000);

    tick();
    applyStimulus(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0);
    tick();
    applyStimulus(1'b1, 3'd7, 16'hBEEF, 1'b0, 3'd0);
    tick();
    applyStimulus(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    raddrA = 3'd3;
    raddrB = 3'd7;
    #1;
    checkOutput("write_r3", rdataA, 16'h1234);
    checkOutput("write_r7", rdataB, 16'hBEEF);
    raddrA = 3'd0;
    #1;
    checkOutput("r0_zero", rdataA, 16'h0000);
    checkOutput("r0_pend_ignored", {8'd0, pendVec}, 16'h0000);

    raddrA = 3'd5;
    applyStimulus(1'b1, 3'd5, 16'hAAAA, 1'b0, 3'd0);
    #1;
    checkOutput("same_cycle_rdataA", rdataA, BYPASS ? 16'hAAAA : 16'h0000);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    #1;
    checkOutput("next_cycle_rdataA", rdataA, 16'hAAAA);

    raddrB = 3'd4;
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4);
    #1;
    checkOutput("pend_before_edge_readyB", {15'd0, readyB}, 16'h0001);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    #1;
    checkOutput("pend_set_readyB", {15'd0, readyB}, 16'h0000);
    checkOutput("pend_set_vec", {8'd0, pendVec}, 16'h0010);
    applyStimulus(1'b1, 3'd4, 16'h0042, 1'b0, 3'd0);
    #1;
    checkOutput("retire_same_cycle_readyB", {15'd0, readyB}, BYPASS ? 16'h0001 : 16'h0000);
    checkOutput("retire_same_cycle_rdataB", rdataB, BYPASS ? 16'h0042 : 16'h0000);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    #1;
    checkOutput("retire_readyB", {15'd0, readyB}, 16'h0001);
    checkOutput("retire_rdataB", rdataB, 16'h0042);
    checkOutput("retire_vec", {8'd0, pendVec}, 16'h0000);

    raddrA = 3'd2;
    applyStimulus(1'b1, 3'd2, 16'h5555, 1'b1, 3'd2);
    #1;
    checkOutput("same_idx_readyA_before", {15'd0, readyA}, 16'h0001);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    #1;
    checkOutput("same_idx_vec", {8'd0, pendVec}, 16'h0004);
    checkOutput("same_idx_data", rdataA, 16'h5555);
    checkOutput("same_idx_readyA", {15'd0, readyA}, 16'h0000);

    applyStimulus(1'b1, 3'd2, 16'h2222, 1'b1, 3'd6);
    tick();
    checkOutput("diff_idx_vec1", {8'd0, pendVec}, 16'h0040);
    applyStimulus(1'b1, 3'd6, 16'h6666, 1'b1, 3'd1);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    raddrA = 3'd6;
    raddrB = 3'd2;
    #1;
    checkOutput("diff_idx_vec2", {8'd0, pendVec}, 16'h0002);
    checkOutput("diff_idx_r6", rdataA, 16'h6666);
    checkOutput("diff_idx_r2", rdataB, 16'h2222);

    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2);
    tick();
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3);
    tick();
    checkOutput("multi_pend_vec", {8'd0, pendVec}, 16'h000E);
    applyStimulus(1'b1, 3'd5, 16'h9999, 1'b1, 3'd7);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async_reset_vec", {8'd0, pendVec}, 16'h0000);
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    for (int a = 0; a < 8; a++) begin
      raddrA = 3'(a);
      raddrB = 3'(a);
      #1;
      checkOutput("async_reset_rdataA", rdataA, 16'h0000);
      checkOutput("async_reset_rdataB", rdataB, 16'h0000);
      checkOutput("async_reset_readyA", {15'd0, readyA}, 16'h0001);
    end
    rstN = 1'b1;
    tick();
    raddrA = 3'd5;
    raddrB = 3'd7;
    #1;
    checkOutput("discarded_write_r5", rdataA, 16'h0000);
    checkOutput("discarded_pend_vec", {8'd0, pendVec}, 16'h0000);
    checkOutput("discarded_readyB", {15'd0, readyB}, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
